// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment display.
// Segment patterns are active low, bit 7 = dp, bits 6:0 = g..a.
package seg7_pkg;

   localparam int NDIG  = 4;
   localparam int BCD_W = 4 * NDIG;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   localparam logic [7:0] SEG_TABLE [10] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   typedef enum logic {IDLE, CONV} conv_state_t;

   // Non-decimal nibbles never occur in a valid result; show them as dark.
   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      return (d < 4'd10) ? SEG_TABLE[d] : SEG_BLANK;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle, VAL_W cycles busy.
// bcd/ovf are valid only while done is high; start is ignored while busy.
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int VAL_W = 14
) (
   input  logic             MHz,
   input  logic             rst,
   input  logic             start,
   input  logic [VAL_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd,
   output logic             ovf
);

   localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

   conv_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [VAL_W-1:0] shreg, shreg_nxt;
   logic [BCD_W-1:0] acc, acc_adj, acc_nxt;
   logic             big;
   logic             last_step;

   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < NDIG; i++) begin
         if (acc[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
      {acc_nxt, shreg_nxt} = {acc_adj, shreg} << 1;
   end

   assign last_step = (state == CONV) && (cnt == CNT_W'(VAL_W - 1));

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      bcd       = acc_nxt;
      ovf       = big;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = CONV;
         end
         CONV: begin
            busy = 1'b1;
            if (last_step) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge MHz) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         acc   <= '0;
         big   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            if (start) begin
               shreg <= bin;
               acc   <= '0;
               cnt   <= '0;
               big   <= (32'(bin) > 32'd9999);
            end
         end else begin
            shreg <= shreg_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Binary count to 4-digit multiplexed common-anode display with change-triggered BCD conversion.
// seg/an are registered one cycle behind the digit index and display registers.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int CLK_DIV = 5000,
   parameter int DIGITS  = 4,
   parameter int VAL_W   = 14
) (
   input  logic              MHz,
   input  logic              rst,
   input  logic [VAL_W-1:0]  value,
   input  logic              blank_lz,
   output logic [7:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              busy,
   output logic              ovf
);

   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = $clog2(DIGITS);

   logic [VAL_W-1:0]  last_val;
   logic              start;
   logic              done;
   logic [BCD_W-1:0]  conv_bcd;
   logic              conv_ovf;
   logic [BCD_W-1:0]  disp;
   logic [PRE_W-1:0]  pre;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        cur;
   logic [DIGITS-1:0] zero_up;
   logic              run;
   logic [7:0]        seg_nxt;

   // A change arriving mid-conversion is picked up once the converter is idle again.
   assign start = !busy && (value != last_val);

   bin2bcd_seq #(
      .VAL_W (VAL_W)
   ) u_conv (
      .MHz   (MHz),
      .rst   (rst),
      .start (start),
      .bin   (value),
      .busy  (busy),
      .done  (done),
      .bcd   (conv_bcd),
      .ovf   (conv_ovf)
   );

   always_comb begin
      run     = 1'b1;
      zero_up = '0;
      // zero_up[i]: digit i and every digit above it are zero
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run        = run & (disp[4*i +: 4] == 4'd0);
         zero_up[i] = run;
      end
      cur = disp[{idx, 2'b00} +: 4];
      if (ovf)
         seg_nxt = SEG_DASH;
      else if (blank_lz && (idx != '0) && zero_up[idx])
         seg_nxt = SEG_BLANK;
      else
         seg_nxt = seg_decode(cur);
   end

   always_ff @(posedge MHz) begin
      if (rst) begin
         last_val <= '0;
         disp     <= '0;
         ovf      <= 1'b0;
         pre      <= '0;
         idx      <= '0;
         seg      <= SEG_BLANK;
         an       <= '1;
      end else begin
         if (start)
            last_val <= value;
         if (done) begin
            disp <= conv_bcd;
            ovf  <= conv_ovf;
         end
         if (pre == PRE_W'(CLK_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end else begin
            pre <= pre + PRE_W'(1);
         end
         seg <= seg_nxt;
         an  <= ~(DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: per-cycle decimal-arithmetic model plus directed scan checks.
module tb_seg7_scan_display;

   localparam int CLK_DIV = 4;
   localparam int DIGITS  = 4;
   localparam int VAL_W   = 14;

   logic              MHz = 1'b0;
   logic              rst = 1'b1;
   logic [VAL_W-1:0]  value = '0;
   logic              blank_lz = 1'b0;
   logic [7:0]        seg;
   logic [DIGITS-1:0] an;
   logic              busy;
   logic              ovf;

   int checks = 0;
   int errors = 0;

   seg7_scan_display #(
      .CLK_DIV (CLK_DIV),
      .DIGITS  (DIGITS),
      .VAL_W   (VAL_W)
   ) dut (
      .MHz      (MHz),
      .rst      (rst),
      .value    (value),
      .blank_lz (blank_lz),
      .seg      (seg),
      .an       (an),
      .busy     (busy),
      .ovf      (ovf)
   );

   always #5 MHz = ~MHz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         default: return 8'h90;
      endcase
   endfunction

   // Model: decimal value on display, conversion as a countdown, scan position from elapsed cycles.
   int   m_last = 0, m_conv = 0, m_left = 0, m_disp = 0, m_cyc = 0;
   bit   m_ovf = 1'b0, m_on = 1'b0;
   logic [7:0] e_seg = 8'hFF;
   logic [3:0] e_an = 4'hF;
   logic       e_busy = 1'b0, e_ovf = 1'b0;

   always @(posedge MHz) begin
      int idx, p10;
      if (rst) begin
         e_seg  = 8'hFF;
         e_an   = 4'hF;
         m_last = 0;
         m_left = 0;
         m_disp = 0;
         m_ovf  = 1'b0;
         m_cyc  = 0;
      end else begin
         idx = (m_cyc / CLK_DIV) % DIGITS;
         p10 = 1;
         for (int k = 0; k < idx; k++) p10 = p10 * 10;
         e_an = ~(4'b0001 << idx);
         if (m_ovf)
            e_seg = 8'hBF;
         else if (blank_lz && idx > 0 && m_disp < p10)
            e_seg = 8'hFF;
         else
            e_seg = pat((m_disp / p10) % 10);
         m_cyc++;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_disp = m_conv % 10000;
               m_ovf  = (m_conv > 9999);
            end
         end else if (int'(value) != m_last) begin
            m_last = int'(value);
            m_conv = int'(value);
            m_left = VAL_W;
         end
      end
      e_busy = (m_left > 0);
      e_ovf  = m_ovf;
      m_on   = 1'b1;
   end

   always @(negedge MHz) begin
      if (m_on) begin
         chk("model seg",  32'(seg),  32'(e_seg));
         chk("model an",   32'(an),   32'(e_an));
         chk("model busy", 32'(busy), 32'(e_busy));
         chk("model ovf",  32'(ovf),  32'(e_ovf));
      end
   end

   // Wait for a fresh units-digit slot, then check all four digit slots in order.
   task automatic scan(input string name, input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
      logic [7:0] exp [4];
      logic [3:0] sel;
      int n;
      exp = '{s0, s1, s2, s3};
      n = 0;
      while (an == 4'b1110 && n < 64) begin @(negedge MHz); n++; end
      for (int k = 0; k < 4; k++) begin
         sel = ~(4'b0001 << k);
         n = 0;
         while (an != sel && n < 64) begin @(negedge MHz); n++; end
         chk($sformatf("%s an%0d", name, k), 32'(an), 32'(sel));
         chk($sformatf("%s seg%0d", name, k), 32'(seg), 32'(exp[k]));
      end
   endtask

   task automatic wait_busy(input logic lvl);
      int n;
      n = 0;
      while (busy !== lvl && n < 200) begin @(negedge MHz); n++; end
   endtask

   task automatic conv_len(output int len);
      wait_busy(1'b1);
      len = 0;
      while (busy === 1'b1 && len < 200) begin @(negedge MHz); len++; end
   endtask

   initial begin
      int len, gap;
      rst = 1'b1;
      value = '0;
      blank_lz = 1'b0;
      repeat (3) @(negedge MHz);
      chk("reset seg",  32'(seg),  32'hFF);
      chk("reset an",   32'(an),   32'hF);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset ovf",  32'(ovf),  32'h0);
      rst = 1'b0;
      @(negedge MHz);
      chk("first an", 32'(an), 32'hE);
      scan("zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      blank_lz = 1'b1;
      scan("zero blank", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

      blank_lz = 1'b0;
      value = 14'd1234;
      conv_len(len);
      chk("1234 busy len", 32'(len), 32'd14);
      scan("1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

      blank_lz = 1'b1;
      value = 14'd7;
      conv_len(len);
      scan("7 blank", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
      value = 14'd1005;
      conv_len(len);
      scan("1005 blank", 8'h92, 8'hC0, 8'hC0, 8'hF9);

      value = 14'd10000;
      conv_len(len);
      chk("10000 ovf", 32'(ovf), 32'h1);
      scan("10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

      // Reset during the 5th conversion cycle discards the result and the overflow flag.
      value = 14'd4321;
      wait_busy(1'b1);
      repeat (4) @(negedge MHz);
      chk("mid busy", 32'(busy), 32'h1);
      rst = 1'b1;
      value = '0;
      @(negedge MHz);
      chk("abort busy", 32'(busy), 32'h0);
      chk("abort ovf",  32'(ovf),  32'h0);
      rst = 1'b0;
      scan("after abort", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

      value = 14'd9999;
      conv_len(len);
      chk("9999 ovf", 32'(ovf), 32'h0);
      scan("9999", 8'h90, 8'h90, 8'h90, 8'h90);

      // Change 5 -> 6 while the first conversion is running.
      value = 14'd5;
      wait_busy(1'b1);
      len = 0;
      while (busy === 1'b1 && len < 200) begin
         if (len == 3) value = 14'd6;
         @(negedge MHz);
         len++;
      end
      chk("first window", 32'(len), 32'd14);
      gap = 0;
      while (busy !== 1'b1 && gap < 10) begin @(negedge MHz); gap++; end
      chk("idle gap", 32'(gap), 32'd1);
      conv_len(len);
      chk("second window", 32'(len), 32'd14);
      scan("final 6", 8'h82, 8'hFF, 8'hFF, 8'hFF);

      repeat (2) @(negedge MHz);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
